// File: rtl/exe_stage_sync.sv
// -----------------------------------------------------------------------------
// exe_stage_sync
//
// Purpose:
//   Clocked execute stage that sits between decode and writeback. It accepts
//   one instruction per valid/ready handshake and evaluates it over a
//   programmable number of cycles. Each result is classified as a branch
//   (instruction == MAGIC) or a register write. Results go into a DEPTH-entry
//   output FIFO, so the downstream stage can stall without losing work.
//
// Ports:
//   clk            in   1       rising-edge clock
//   reset          in   1       asynchronous, active-high reset
//   in_req         in   1       upstream valid
//   in_ack         out  1       upstream ready (IDLE and not in reset)
//   instruction    in   DATA_W  captured on accept
//   lat_cfg        in   LAT_W   evaluation latency, captured on accept (0 -> 1)
//   out_req        out  1       result valid (FIFO not empty)
//   out_ack        in   1       downstream ready
//   target_address out  DATA_W  FIFO head: branch ? 0 : DFLT_TGT
//   qual_branch    out  1       FIFO head is a branch
//   qual_regwrite  out  1       FIFO head is a register write
//   busy           out  1       evaluating, holding, or FIFO not empty
//   br_count       out  16      saturating count of branch results pushed
//   op_count       out  16      saturating count of all results pushed
//
// Configuration macro:
//   EXE_STAGE_STATS_EN - when defined, br_count/op_count are live counters.
//                        When undefined, both ports are tied to 0 and no
//                        counter flops are built.
//
// The reset input is assumed to be released synchronously to clk by the
// surrounding reset network. Assertion may be asynchronous.
// -----------------------------------------------------------------------------
module exe_stage_sync #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] MAGIC    = 32'hCAFEBABE,
  parameter logic [31:0] DFLT_TGT = 32'hDEAFBEEF,
  parameter int          LAT_W    = 4,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_req,
  output logic              in_ack,
  input  logic [DATA_W-1:0] instruction,
  input  logic [LAT_W-1:0]  lat_cfg,
  output logic              out_req,
  input  logic              out_ack,
  output logic [DATA_W-1:0] target_address,
  output logic              qual_branch,
  output logic              qual_regwrite,
  output logic              busy,
  output logic [15:0]       br_count,
  output logic [15:0]       op_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [DATA_W-1:0] MAGIC_V  = MAGIC[DATA_W-1:0];
  localparam logic [DATA_W-1:0] DFLT_V   = DFLT_TGT[DATA_W-1:0];
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0]  FULL_OCC = OCC_W'(DEPTH);
  localparam logic [LAT_W-1:0]  ONE_LAT  = LAT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  cnt;
  logic [DATA_W-1:0] inst_q;

  // Only the branch flag is stored per entry. Target and regwrite are
  // derived from it at the FIFO head.
  logic              fifo_br [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic push;
  logic res_branch;
  logic head_br;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == FULL_OCC);
  assign pop        = !fifo_empty && out_ack;
  // A full FIFO can still take a result when its head leaves on the same edge.
  assign push_ok    = !fifo_full || pop;
  assign push       = (((state == EVAL) && (cnt == ONE_LAT)) || (state == HOLD)) && push_ok;
  // The result is always classified from the captured instruction.
  assign res_branch = (inst_q == MAGIC_V);

  assign in_ack = (state == IDLE) && !reset;
  assign busy   = (state != IDLE) || !fifo_empty;

  // Outputs read as zero whenever the FIFO is empty, which includes reset.
  assign head_br        = fifo_br[rd_ptr];
  assign out_req        = !fifo_empty;
  assign qual_branch    = !fifo_empty && head_br;
  assign qual_regwrite  = !fifo_empty && !head_br;
  assign target_address = (!fifo_empty && !head_br) ? DFLT_V : '0;

  // Control FSM: capture on accept, count down, then push or wait in HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      inst_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_req) begin
            inst_q <= instruction;
            cnt    <= (lat_cfg == '0) ? ONE_LAT : lat_cfg;
            state  <= EVAL;
          end
        end
        EVAL: begin
          if (cnt == ONE_LAT) begin
            cnt   <= '0;
            state <= push_ok ? IDLE : HOLD;
          end else begin
            cnt <= cnt - ONE_LAT;
          end
        end
        HOLD: begin
          if (push_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Circular result FIFO. Pointers wrap at DEPTH, so DEPTH need not be a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_br[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_br[wr_ptr] <= res_branch;
        wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

`ifdef EXE_STAGE_STATS_EN
  logic [15:0] br_cnt_q;
  logic [15:0] op_cnt_q;

  // Push statistics. Both counters stop at all-ones and never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q <= '0;
      op_cnt_q <= '0;
    end else if (push) begin
      if (op_cnt_q != 16'hFFFF) begin
        op_cnt_q <= op_cnt_q + 16'd1;
      end
      if (res_branch && (br_cnt_q != 16'hFFFF)) begin
        br_cnt_q <= br_cnt_q + 16'd1;
      end
    end
  end

  assign br_count = br_cnt_q;
  assign op_count = op_cnt_q;
`else
  assign br_count = 16'h0000;
  assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_exe_stage_sync.sv
// -----------------------------------------------------------------------------
// tb_exe_stage_sync
//
// Self-checking bench for exe_stage_sync with default parameters (DEPTH=2).
// Table vectors exercise single instructions. Hand-written sequences cover
// back-pressure, the HOLD state, push/pop on a full FIFO, reset in mid-flight,
// and the optional statistics counters. Every result the DUT pops is compared
// with a scoreboard entry that was computed when the instruction was accepted.
// -----------------------------------------------------------------------------
module tb_exe_stage_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_req;
  logic        in_ack;
  logic [31:0] instruction;
  logic [3:0]  lat_cfg;
  logic        out_req;
  logic        out_ack;
  logic [31:0] target_address;
  logic        qual_branch;
  logic        qual_regwrite;
  logic        busy;
  logic [15:0] br_count;
  logic [15:0] op_count;

  exe_stage_sync dut (
    .clk            (clk),
    .reset          (reset),
    .in_req         (in_req),
    .in_ack         (in_ack),
    .instruction    (instruction),
    .lat_cfg        (lat_cfg),
    .out_req        (out_req),
    .out_ack        (out_ack),
    .target_address (target_address),
    .qual_branch    (qual_branch),
    .qual_regwrite  (qual_regwrite),
    .busy           (busy),
    .br_count       (br_count),
    .op_count       (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  lat;
    int          exp_lat;
    logic        exp_branch;
    logic [31:0] exp_target;
    logic        exp_regwrite;
  } vec_t;

  typedef struct {
    logic [31:0] target;
    logic        branch;
    logic        regwrite;
  } res_t;

  res_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pops   = 0;

  // Compares one value and logs any failure.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model for a single result.
  function automatic res_t model(input logic [31:0] instr);
    res_t r;
    r.branch   = (instr == 32'hCAFEBABE);
    r.regwrite = !r.branch;
    r.target   = r.branch ? 32'h0 : 32'hDEAFBEEF;
    return r;
  endfunction

  // Advances one clock. Handshakes are sampled before the edge, and outputs
  // settle 1 time unit after it.
  task automatic tick();
    res_t r;
    if (out_req && out_ack) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pop", 64'd1, 64'd0);
      end else begin
        r = sb.pop_front();
        checkOutput("sb_target", target_address, r.target);
        checkOutput("sb_branch", qual_branch, r.branch);
        checkOutput("sb_regwrite", qual_regwrite, r.regwrite);
        n_pops++;
      end
    end
    if (in_req && in_ack) begin
      sb.push_back(model(instruction));
    end
    @(posedge clk);
    #1;
  endtask

  // Sends one instruction with out_ack held high, measures its latency, and
  // checks the head against the table.
  task automatic applyStimulus(input vec_t v, input int idx);
    int n;
    instruction = v.instr;
    lat_cfg     = v.lat;
    in_req      = 1'b1;
    out_ack     = 1'b1;
    checkOutput($sformatf("v%0d_in_ack_idle", idx), in_ack, 1);
    tick();
    in_req      = 1'b0;
    instruction = $urandom;
    lat_cfg     = 4'($urandom_range(0, 15));
    checkOutput($sformatf("v%0d_in_ack_eval", idx), in_ack, 0);
    n = 0;
    while (!out_req && n < 40) begin
      tick();
      n++;
    end
    checkOutput($sformatf("v%0d_latency", idx), n, v.exp_lat);
    checkOutput($sformatf("v%0d_branch", idx), qual_branch, v.exp_branch);
    checkOutput($sformatf("v%0d_target", idx), target_address, v.exp_target);
    checkOutput($sformatf("v%0d_regwrite", idx), qual_regwrite, v.exp_regwrite);
    tick();
    checkOutput($sformatf("v%0d_drained", idx), out_req, 0);
  endtask

  initial begin
    logic [31:0] vals[4];
    int          n;
    int          pops_before;
    logic        seen_req;

    vecs[0] = '{32'hCAFEBABE, 4'd3,  3,  1'b1, 32'h00000000, 1'b0};
    vecs[1] = '{32'h12345678, 4'd0,  1,  1'b0, 32'hDEAFBEEF, 1'b1};
    vecs[2] = '{32'hCAFEBABE, 4'd1,  1,  1'b1, 32'h00000000, 1'b0};
    vecs[3] = '{32'hCAFEBABF, 4'd2,  2,  1'b0, 32'hDEAFBEEF, 1'b1};
    vecs[4] = '{32'hCAFEBABE, 4'd15, 15, 1'b1, 32'h00000000, 1'b0};

    vals[0] = 32'hCAFEBABE;
    vals[1] = 32'h11111111;
    vals[2] = 32'hCAFEBABE;
    vals[3] = 32'h22222222;

    reset       = 1'b1;
    in_req      = 1'b0;
    out_ack     = 1'b0;
    instruction = '0;
    lat_cfg     = '0;
    #2;
    checkOutput("rst_in_ack", in_ack, 0);
    checkOutput("rst_out_req", out_req, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_target", target_address, 0);
    checkOutput("rst_qual", {qual_branch, qual_regwrite}, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ack", in_ack, 1);

    // Table vectors: three branches and two non-branches.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i);
    end

`ifdef EXE_STAGE_STATS_EN
    checkOutput("stats_br", br_count, 16'd3);
    checkOutput("stats_op", op_count, 16'd5);
    force dut.br_cnt_q = 16'hFFFF;
    force dut.op_cnt_q = 16'hFFFF;
    #1;
    release dut.br_cnt_q;
    release dut.op_cnt_q;
    applyStimulus(vecs[2], 5);
    checkOutput("stats_br_sat", br_count, 16'hFFFF);
    checkOutput("stats_op_sat", op_count, 16'hFFFF);
`else
    checkOutput("stats_br_off", br_count, 16'd0);
    checkOutput("stats_op_off", op_count, 16'd0);
`endif

    // Back-pressure: two results fill the FIFO and the third waits in HOLD.
    pops_before = n_pops;
    out_ack     = 1'b0;
    lat_cfg     = 4'd1;
    for (int k = 0; k < 3; k++) begin
      instruction = vals[k];
      in_req      = 1'b1;
      n = 0;
      while (!in_ack && n < 20) begin
        tick();
        n++;
      end
      checkOutput($sformatf("bp_ack_%0d", k), in_ack, 1);
      tick();
    end
    in_req = 1'b0;
    tick();
    tick();
    checkOutput("hold_in_ack", in_ack, 0);
    checkOutput("hold_out_req", out_req, 1);
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_head_branch", qual_branch, 1);

    // One pop while full and holding: the held result enters on the same edge.
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    checkOutput("swap_in_ack", in_ack, 1);
    checkOutput("swap_out_req", out_req, 1);
    checkOutput("swap_head_target", target_address, 32'hDEAFBEEF);

    // Fourth instruction goes into HOLD again behind the full FIFO.
    instruction = vals[3];
    in_req      = 1'b1;
    tick();
    in_req = 1'b0;
    tick();
    checkOutput("hold2_in_ack", in_ack, 0);

    out_ack = 1'b1;
    n = 0;
    while ((out_req || busy) && n < 40) begin
      tick();
      n++;
    end
    checkOutput("bp_pops", n_pops - pops_before, 4);
    checkOutput("bp_sb_empty", sb.size(), 0);
    checkOutput("bp_busy", busy, 0);

    // Reset with one queued result and an instruction in mid-evaluation.
    out_ack     = 1'b0;
    lat_cfg     = 4'd1;
    instruction = 32'hCAFEBABE;
    in_req      = 1'b1;
    tick();
    in_req = 1'b0;
    tick();
    instruction = 32'h0BADF00D;
    lat_cfg     = 4'd4;
    in_req      = 1'b1;
    tick();
    in_req = 1'b0;
    tick();
    tick();
    checkOutput("pre_rst_out_req", out_req, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_out_req", out_req, 0);
    checkOutput("mid_rst_in_ack", in_ack, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_target", target_address, 0);
    sb.delete();
    tick();
    tick();
    reset   = 1'b0;
    out_ack = 1'b1;
    seen_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen_req = seen_req | out_req;
    end
    checkOutput("post_rst_no_output", seen_req, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_ready", in_ack, 1);
    checkOutput("post_rst_br_count", br_count, 0);
    checkOutput("post_rst_op_count", op_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
